// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, valid/ready on both sides.
// Define CORDIC_GAIN_COMP_EN to add a SCALE state that removes the CORDIC gain (x/y * K).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | ready for a new vector; captures x/y/z on accept
// S_ROTATE | one micro-rotation per cycle, shift amount = i
// S_SCALE  | gain compensation multiply (CORDIC_GAIN_COMP_EN only)
// S_DONE   | result presented on x_o/y_o/z_o until ready_i

module cordic_rotator #(
   parameter int WIDTH      = 16,
   parameter int ITERATIONS = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   input  logic [WIDTH-1:0] z_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] x_o,
   output logic [WIDTH-1:0] y_o,
   output logic [WIDTH-1:0] z_o
);

`ifdef CORDIC_GAIN_COMP_EN
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ROTATE = 2'd1,
      S_SCALE  = 2'd2,
      S_DONE   = 2'd3
   } state_e;
`else
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ROTATE = 2'd1,
      S_DONE   = 2'd3
   } state_e;
`endif

   localparam logic [3:0] LAST_ITER = 4'(ITERATIONS - 1);

`ifdef CORDIC_GAIN_COMP_EN
   localparam longint GAIN_K_L =
      (longint'(607253) * (longint'(1) << (WIDTH - 2)) + longint'(500000)) / longint'(1000000);
   localparam logic [2*WIDTH-1:0] GAIN_K = (2*WIDTH)'(GAIN_K_L);

   // Sign-extended 2*WIDTH product; the logical shift only discards bits we never keep,
   // so the retained slice equals an arithmetic shift (truncation toward -inf).
   function automatic logic [WIDTH-1:0] gain_scale(input logic [WIDTH-1:0] v);
      logic [2*WIDTH-1:0] p;
      p = {{WIDTH{v[WIDTH-1]}}, v} * GAIN_K;
      return WIDTH'(p >> (WIDTH - 2));
   endfunction
`endif

   // atan(2^-i) held in Q2.30, narrowed to the Q3.(WIDTH-3) angle scale with round-half-up.
   function automatic logic [WIDTH-1:0] atan_rom(input logic [3:0] idx);
      logic [31:0] q30;
      case (idx)
         4'd0:    q30 = 32'd843314857;
         4'd1:    q30 = 32'd497837829;
         4'd2:    q30 = 32'd263043836;
         4'd3:    q30 = 32'd133525158;
         4'd4:    q30 = 32'd67021686;
         4'd5:    q30 = 32'd33543515;
         4'd6:    q30 = 32'd16775850;
         4'd7:    q30 = 32'd8388437;
         4'd8:    q30 = 32'd4194283;
         4'd9:    q30 = 32'd2097149;
         4'd10:   q30 = 32'd1048576;
         4'd11:   q30 = 32'd524288;
         4'd12:   q30 = 32'd262144;
         4'd13:   q30 = 32'd131072;
         4'd14:   q30 = 32'd65536;
         default: q30 = 32'd32768;
      endcase
      return WIDTH'(({1'b0, q30} + (33'd1 << (32 - WIDTH))) >> (33 - WIDTH));
   endfunction

   state_e                   state_q, state_d;
   logic        [3:0]        i_q, i_d;
   logic signed [WIDTH-1:0]  x_q, x_d;
   logic signed [WIDTH-1:0]  y_q, y_d;
   logic signed [WIDTH-1:0]  z_q, z_d;

   logic signed [WIDTH-1:0]  x_sh, y_sh;
   logic signed [WIDTH-1:0]  atan_cur;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
      end
   end

   always_comb begin
      x_sh     = x_q >>> i_q;
      y_sh     = y_q >>> i_q;
      atan_cur = $signed(atan_rom(i_q));

      state_d = state_q;
      i_d     = i_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;

      case (state_q)
         S_IDLE: begin
            if (valid_i) begin
               x_d     = $signed(x_i);
               y_d     = $signed(y_i);
               z_d     = $signed(z_i);
               i_d     = '0;
               state_d = S_ROTATE;
            end
         end
         S_ROTATE: begin
            if (!z_q[WIDTH-1]) begin
               x_d = x_q - y_sh;
               y_d = y_q + x_sh;
               z_d = z_q - atan_cur;
            end else begin
               x_d = x_q + y_sh;
               y_d = y_q - x_sh;
               z_d = z_q + atan_cur;
            end
            i_d = i_q + 4'd1;
            if (i_q == LAST_ITER) begin
`ifdef CORDIC_GAIN_COMP_EN
               state_d = S_SCALE;
`else
               state_d = S_DONE;
`endif
            end
         end
`ifdef CORDIC_GAIN_COMP_EN
         S_SCALE: begin
            x_d     = $signed(gain_scale(x_q));
            y_d     = $signed(gain_scale(y_q));
            state_d = S_DONE;
         end
`endif
         S_DONE: begin
            if (ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ready_o = (state_q == S_IDLE);
   assign valid_o = (state_q == S_DONE);
   assign x_o     = x_q;
   assign y_o     = y_q;
   assign z_o     = z_q;

endmodule

// File: tb/tb_cordic_rotator.sv
// Self-checking bench for cordic_rotator (WIDTH=16, ITERATIONS=8); honours CORDIC_GAIN_COMP_EN.
// Reference: integer micro-rotation loop from the angle table plus real-valued trig for tolerances.

module tb_cordic_rotator;
   localparam int W    = 16;
   localparam int ITER = 8;
`ifdef CORDIC_GAIN_COMP_EN
   localparam bit COMP = 1'b1;
`else
   localparam bit COMP = 1'b0;
`endif
   localparam int LAT    = ITER + (COMP ? 1 : 0);
   localparam int PERIOD = ITER + 2 + (COMP ? 1 : 0);
   localparam int TOL_XY = COMP ? 64 : 128;
   localparam real PI    = 3.14159265358979;
   localparam int ATAN16 [16] = '{6434, 3798, 2007, 1019, 511, 256, 128, 64,
                                  32, 16, 8, 4, 2, 1, 1, 0};

   logic          clk_i   = 1'b0;
   logic          rst_ni  = 1'b0;
   logic          valid_i = 1'b0;
   logic          ready_i = 1'b0;
   logic [W-1:0]  x_i = '0, y_i = '0, z_i = '0;
   logic          ready_o, valid_o;
   logic [W-1:0]  x_o, y_o, z_o;

   int checks   = 0;
   int failures = 0;

   cordic_rotator #(.WIDTH(W), .ITERATIONS(ITER)) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .x_i     (x_i),
      .y_i     (y_i),
      .z_i     (z_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .x_o     (x_o),
      .y_o     (y_o),
      .z_o     (z_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic void model(input logic [W-1:0] xi, input logic [W-1:0] yi,
                                 input logic [W-1:0] zi, output logic [W-1:0] xo,
                                 output logic [W-1:0] yo, output logic [W-1:0] zo);
      int x, y, z, xn;
      x = int'($signed(xi));
      y = int'($signed(yi));
      z = int'($signed(zi));
      for (int i = 0; i < ITER; i++) begin
         if (z >= 0) begin
            xn = x - (y >>> i);
            y  = y + (x >>> i);
            z  = z - ATAN16[i];
         end else begin
            xn = x + (y >>> i);
            y  = y - (x >>> i);
            z  = z + ATAN16[i];
         end
         x = xn;
      end
      if (COMP) begin
         x = int'((longint'(x) * 64'sd9949) >>> 14);
         y = int'((longint'(y) * 64'sd9949) >>> 14);
      end
      xo = 16'(x);
      yo = 16'(y);
      zo = 16'(z);
   endfunction

   function automatic real gain();
      real g, p;
      g = 1.0;
      p = 1.0;
      for (int i = 0; i < ITER; i++) begin
         g = g * $sqrt(1.0 + p);
         p = p / 4.0;
      end
      return COMP ? 1.0 : g;
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic logic [W-1:0] rnd_xy();
      return 16'(int'($urandom_range(22000, 0)) - 11000);
   endfunction

   function automatic logic [W-1:0] rnd_z();
      return 16'(int'($urandom_range(25736, 0)) - 12868);
   endfunction

   // All tasks start and end 1 time unit after a rising edge.
   task automatic start_vec(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [W-1:0] z, output bit ok);
      int n;
      n = 0;
      while (!ready_o && n < 50) begin
         @(posedge clk_i); #1;
         n++;
      end
      ok      = ready_o;
      x_i     = x;
      y_i     = y;
      z_i     = z;
      valid_i = 1'b1;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
   endtask

   task automatic wait_result(output int lat, output bit ok);
      lat = 0;
      while (!valid_o && lat < 50) begin
         @(posedge clk_i); #1;
         lat++;
      end
      ok = valid_o;
   endtask

   task automatic pop_result();
      ready_i = 1'b1;
      @(posedge clk_i); #1;
      ready_i = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid_o: got %b expected 0", valid_o); end
      checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready_o: got %b expected 1", ready_o); end
      checks++; if (x_o !== 16'd0) begin failures++; $display("FAIL rst_x_o: got %0d expected 0", x_o); end
      checks++; if (y_o !== 16'd0) begin failures++; $display("FAIL rst_y_o: got %0d expected 0", y_o); end
      checks++; if (z_o !== 16'd0) begin failures++; $display("FAIL rst_z_o: got %0d expected 0", z_o); end
      repeat (2) begin @(posedge clk_i); #1; end
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
         failures++; $display("FAIL post_rst_idle: got ready=%b valid=%b expected ready=1 valid=0", ready_o, valid_o);
      end
   endtask

   // Directed vector: exact model match, latency, and closeness to real rotation.
   task automatic test_directed(input string name, input int x, input int y, input int z,
                                input bit check_z_res);
      logic [W-1:0] ex, ey, ez;
      bit ok;
      int lat, ax, ay, rx, ry;
      real ang, g;
      model(16'(x), 16'(y), 16'(z), ex, ey, ez);
      start_vec(16'(x), 16'(y), 16'(z), ok);
      checks++; if (!ok) begin failures++; $display("FAIL %s_accept: ready_o never rose", name); end
      wait_result(lat, ok);
      checks++; if (!ok) begin failures++; $display("FAIL %s_timeout: valid_o never rose", name); end
      checks++; if (lat !== LAT) begin failures++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, LAT); end
      checks++; if (x_o !== ex) begin failures++; $display("FAIL %s_x: got %0d expected %0d", name, $signed(x_o), $signed(ex)); end
      checks++; if (y_o !== ey) begin failures++; $display("FAIL %s_y: got %0d expected %0d", name, $signed(y_o), $signed(ey)); end
      checks++; if (z_o !== ez) begin failures++; $display("FAIL %s_z: got %0d expected %0d", name, $signed(z_o), $signed(ez)); end
      ang = real'(z) / 8192.0;
      g   = gain();
      rx  = int'(g * (real'(x) * $cos(ang) - real'(y) * $sin(ang)));
      ry  = int'(g * (real'(x) * $sin(ang) + real'(y) * $cos(ang)));
      ax  = int'($signed(x_o));
      ay  = int'($signed(y_o));
      checks++; if (iabs(ax - rx) > TOL_XY) begin failures++; $display("FAIL %s_x_tol: got %0d expected %0d +-%0d", name, ax, rx, TOL_XY); end
      checks++; if (iabs(ay - ry) > TOL_XY) begin failures++; $display("FAIL %s_y_tol: got %0d expected %0d +-%0d", name, ay, ry, TOL_XY); end
      if (check_z_res) begin
         checks++; if (iabs(int'($signed(z_o))) > 64) begin failures++; $display("FAIL %s_z_res: got %0d expected |z|<=64", name, $signed(z_o)); end
      end
      pop_result();
   endtask

   task automatic test_backpressure();
      logic [W-1:0] vx, vy, vz, ex, ey, ez, hx, hy, hz;
      bit ok;
      int lat;
      vx = rnd_xy(); vy = rnd_xy(); vz = rnd_z();
      model(vx, vy, vz, ex, ey, ez);
      start_vec(vx, vy, vz, ok);
      wait_result(lat, ok);
      checks++; if (!ok) begin failures++; $display("FAIL bp_timeout: valid_o never rose"); end
      checks++; if (x_o !== ex || y_o !== ey || z_o !== ez) begin
         failures++; $display("FAIL bp_result: got %0d,%0d,%0d expected %0d,%0d,%0d",
                              $signed(x_o), $signed(y_o), $signed(z_o), $signed(ex), $signed(ey), $signed(ez));
      end
      hx = x_o; hy = y_o; hz = z_o;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            x_i = rnd_xy(); y_i = rnd_xy(); z_i = rnd_z();
            valid_i = 1'b1;
         end
         @(posedge clk_i); #1;
         valid_i = 1'b0;
         checks++; if (x_o !== hx || y_o !== hy || z_o !== hz) begin
            failures++; $display("FAIL bp_stable cycle %0d: got %0d,%0d,%0d expected %0d,%0d,%0d", c,
                                 $signed(x_o), $signed(y_o), $signed(z_o), $signed(hx), $signed(hy), $signed(hz));
         end
         checks++; if (ready_o !== 1'b0 || valid_o !== 1'b1) begin
            failures++; $display("FAIL bp_flags cycle %0d: got ready=%b valid=%b expected ready=0 valid=1", c, ready_o, valid_o);
         end
      end
      pop_result();
      for (int c = 0; c < 3; c++) begin
         checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            failures++; $display("FAIL bp_after_pop cycle %0d: got ready=%b valid=%b expected ready=1 valid=0", c, ready_o, valid_o);
         end
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_reset_mid_op();
      logic [W-1:0] ex, ey, ez, vx, vy, vz;
      bit ok;
      int lat;
      start_vec(rnd_xy(), rnd_xy(), rnd_z(), ok);
      repeat (3) @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      #1;
      checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
         failures++; $display("FAIL midrst_flags: got ready=%b valid=%b expected ready=1 valid=0", ready_o, valid_o);
      end
      checks++; if (x_o !== 16'd0 || y_o !== 16'd0 || z_o !== 16'd0) begin
         failures++; $display("FAIL midrst_outputs: got %0d,%0d,%0d expected 0,0,0", x_o, y_o, z_o);
      end
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      vx = rnd_xy(); vy = rnd_xy(); vz = rnd_z();
      model(vx, vy, vz, ex, ey, ez);
      start_vec(vx, vy, vz, ok);
      wait_result(lat, ok);
      checks++; if (lat !== LAT) begin failures++; $display("FAIL midrst_latency: got %0d expected %0d", lat, LAT); end
      checks++; if (x_o !== ex || y_o !== ey || z_o !== ez) begin
         failures++; $display("FAIL midrst_result: got %0d,%0d,%0d expected %0d,%0d,%0d",
                              $signed(x_o), $signed(y_o), $signed(z_o), $signed(ex), $signed(ey), $signed(ez));
      end
      pop_result();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] ax, ay, az, bx, by, bz;
      logic [W-1:0] ex [2], ey [2], ez [2], gx [2], gy [2], gz [2];
      int ac [2], hs [2];
      int nacc, nhs, cyc;
      bit acc_now, hs_now;
      ax = rnd_xy(); ay = rnd_xy(); az = rnd_z();
      bx = rnd_xy(); by = rnd_xy(); bz = rnd_z();
      model(ax, ay, az, ex[0], ey[0], ez[0]);
      model(bx, by, bz, ex[1], ey[1], ez[1]);
      ac = '{-1, -1}; hs = '{-1, -1};
      gx = '{16'd0, 16'd0}; gy = '{16'd0, 16'd0}; gz = '{16'd0, 16'd0};
      nacc = 0; nhs = 0; cyc = 0;
      x_i = ax; y_i = ay; z_i = az;
      valid_i = 1'b1;
      ready_i = 1'b1;
      while (nhs < 2 && cyc < 100) begin
         acc_now = ready_o && valid_i;
         hs_now  = valid_o && ready_i;
         if (hs_now) begin
            gx[nhs] = x_o; gy[nhs] = y_o; gz[nhs] = z_o;
            hs[nhs] = cyc;
            nhs++;
         end
         if (acc_now && nacc < 2) begin
            ac[nacc] = cyc;
            nacc++;
         end
         @(posedge clk_i); #1;
         cyc++;
         if (acc_now) begin
            if (nacc == 1) begin
               x_i = bx; y_i = by; z_i = bz;
            end else begin
               valid_i = 1'b0;
            end
         end
      end
      valid_i = 1'b0;
      ready_i = 1'b0;
      checks++; if (nhs != 2) begin failures++; $display("FAIL b2b_handshakes: got %0d expected 2", nhs); end
      checks++; if (ac[1] != hs[0] + 1) begin
         failures++; $display("FAIL b2b_second_accept: got cycle %0d expected %0d", ac[1], hs[0] + 1);
      end
      checks++; if (ac[1] - ac[0] != PERIOD) begin
         failures++; $display("FAIL b2b_period: got %0d expected %0d", ac[1] - ac[0], PERIOD);
      end
      for (int k = 0; k < 2; k++) begin
         checks++; if (gx[k] !== ex[k] || gy[k] !== ey[k] || gz[k] !== ez[k]) begin
            failures++; $display("FAIL b2b_result%0d: got %0d,%0d,%0d expected %0d,%0d,%0d", k,
                                 $signed(gx[k]), $signed(gy[k]), $signed(gz[k]),
                                 $signed(ex[k]), $signed(ey[k]), $signed(ez[k]));
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] vx, vy, vz, ex, ey, ez;
      bit ok;
      int lat;
      for (int n = 0; n < 24; n++) begin
         vx = rnd_xy(); vy = rnd_xy(); vz = rnd_z();
         model(vx, vy, vz, ex, ey, ez);
         start_vec(vx, vy, vz, ok);
         wait_result(lat, ok);
         checks++; if (lat !== LAT) begin failures++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, lat, LAT); end
         checks++; if (x_o !== ex || y_o !== ey || z_o !== ez) begin
            failures++; $display("FAIL rnd%0d_result: in %0d,%0d,%0d got %0d,%0d,%0d expected %0d,%0d,%0d", n,
                                 $signed(vx), $signed(vy), $signed(vz),
                                 $signed(x_o), $signed(y_o), $signed(z_o),
                                 $signed(ex), $signed(ey), $signed(ez));
         end
         repeat ($urandom_range(3, 0)) begin @(posedge clk_i); #1; end
         checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL rnd%0d_hold: got valid=%b expected 1", n, valid_o); end
         pop_result();
      end
   endtask

   initial begin
      test_reset();
      test_directed("pi4", 8192, 0, 6434, 1'b0);
      test_directed("neg_pi2", 8192, 0, -12868, 1'b1);
      test_directed("zero_angle", 8192, 0, 0, 1'b0);
      test_backpressure();
      test_reset_mid_op();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
